apb_master_arbiter: RTL

APB master that shares one APB slave port (the timer block's register interface) among NREQ local requesters. Requesters present simple valid/ready transfer requests; the block arbitrates round-robin, sequences the APB SETUP and ACCESS phases, absorbs slave wait states, and returns read data or an error to the winning requester. A timeout counter ends hung transfers with an error.

---
 rtl/apb_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/apb_master_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB master arbiter.
//   APB_* localparams : phase encodings used by the sequencer state.
//   apb_state_e       : sequencer state type.
package apb_pkg;

  localparam logic [1:0] APB_IDLE   = 2'd0;
  localparam logic [1:0] APB_SETUP  = 2'd1;
  localparam logic [1:0] APB_ACCESS = 2'd2;
  localparam logic [1:0] APB_RESP   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = APB_IDLE,
    SETUP  = APB_SETUP,
    ACCESS = APB_ACCESS,
    RESP   = APB_RESP
  } apb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req        : request vector, one bit per requester
//   last_grant : index of the most recently accepted requester
//   grant      : one-hot winner (all zero when nothing requests)
//   grant_idx  : binary index of the winner
//   any        : at least one request present
// The search starts one past last_grant and wraps, so the previous winner
// has the lowest priority.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IDX_W'((int'(last_grant) + k) % N);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by NREQ local requesters. Requests are arbitrated
// round-robin, sequenced through the APB SETUP/ACCESS phases, and the result
// (read data, slave error or timeout) is returned to the winner.
//   clk, reset                          : clock, async active-low reset
//   req_valid/write/addr/wdata          : packed per-requester requests
//   req_ready                           : one-hot acceptance pulse
//   rsp_valid/rdata/err/timeout         : one-hot completion pulse + result
//   psel/penable/pwrite/paddr/pwdata    : APB master outputs
//   prdata/pready/pslverr               : APB slave returns
//
// state  | meaning
// IDLE   | bus idle, arbitrate and accept one request
// SETUP  | APB setup phase (psel=1, penable=0)
// ACCESS | APB access phase, waiting for pready or timeout
// RESP   | bus released, rsp_valid pulsed to the owner
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   rsp_timeout,
  output logic                   psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [ADDR_W-1:0]      paddr,
  output logic [DATA_W-1:0]      pwdata,
  input  logic [DATA_W-1:0]      prdata,
  input  logic                   pready,
  input  logic                   pslverr
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);

  apb_state_e       state_q, state_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NREQ-1:0]   grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_any;

  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [NREQ-1:0]   owner_vec;
  logic              timeout_hit;

  logic [NREQ-1:0]   req_ready_d, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_d, pwdata_d;
  logic [ADDR_W-1:0] paddr_d;
  logic              rsp_err_d, rsp_timeout_d, psel_d, penable_d, pwrite_d;

  rr_arbiter #(.N(NREQ), .IDX_W(IDX_W)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any        (grant_any)
  );

  // grant is one-hot, so OR-ing the masked fields selects the winner.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_write = sel_write | req_write[i];
        sel_addr  = sel_addr  | req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = sel_wdata | req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    owner_vec = '0;
    for (int i = 0; i < NREQ; i++) begin
      owner_vec[i] = (owner_q == IDX_W'(i));
    end
  end

  // pready is checked first in ACCESS, so it wins over a coincident timeout.
  assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_TC);

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    cnt_d         = cnt_q;
    req_ready_d   = '0;
    rsp_valid_d   = '0;
    rsp_rdata_d   = rsp_rdata;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;
    psel_d        = 1'b0;
    penable_d     = 1'b0;
    pwrite_d      = pwrite;
    paddr_d       = paddr;
    pwdata_d      = pwdata;

    case (state_q)
      IDLE: begin
        if (grant_any) begin
          state_d      = SETUP;
          last_grant_d = grant_idx;
          owner_d      = grant_idx;
          req_ready_d  = grant;
          psel_d       = 1'b1;
          pwrite_d     = sel_write;
          paddr_d      = sel_addr;
          pwdata_d     = sel_wdata;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        if (pready) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = owner_vec;
          rsp_rdata_d   = prdata;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
        end else if (timeout_hit) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = owner_vec;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_RST;
      owner_q      <= '0;
      cnt_q        <= '0;
      req_ready    <= '0;
      rsp_valid    <= '0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      rsp_timeout  <= 1'b0;
      psel         <= 1'b0;
      penable      <= 1'b0;
      pwrite       <= 1'b0;
      paddr        <= '0;
      pwdata       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      req_ready    <= req_ready_d;
      rsp_valid    <= rsp_valid_d;
      rsp_rdata    <= rsp_rdata_d;
      rsp_err      <= rsp_err_d;
      rsp_timeout  <= rsp_timeout_d;
      psel         <= psel_d;
      penable      <= penable_d;
      pwrite       <= pwrite_d;
      paddr        <= paddr_d;
      pwdata       <= pwdata_d;
    end
  end

endmodule
